// File: rtl/puf_word_streamer.sv
// Word FIFO plus byte serializer for PUF response words toward the host link.
// Ports: clk/rst_n; in_wr/in_addr/in_data write side with in_full, ovf,
// ovf_clr, level; out_data/out_valid/out_ready/out_last byte stream.
// Option: define PUF_ADDR_HDR_EN to store in_addr and prefix 2 header bytes.
module puf_word_streamer #(
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_wr,
  input  logic [12:0]      in_addr,
  input  logic [127:0]     in_data,
  output logic             in_full,
  output logic             ovf,
  input  logic             ovf_clr,
  output logic [LVL_W-1:0] level,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  localparam int AW = LVL_W - 1;
`ifdef PUF_ADDR_HDR_EN
  localparam int FW = 141;
  localparam int NB = 18;
`else
  localparam int FW = 128;
  localparam int NB = 16;
`endif
  localparam int SW = NB * 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1
  } state_t;

  logic [FW-1:0]    mem [DEPTH];
  logic [LVL_W-1:0] wptr;
  logic [LVL_W-1:0] rptr;
  logic [FW-1:0]    wr_word;
  logic [SW-1:0]    head_frame;
  logic [SW-1:0]    sr;
  logic [4:0]       cnt;
  logic             push;
  state_t           state;

`ifdef PUF_ADDR_HDR_EN
  assign wr_word = {in_addr, in_data};
`else
  logic unused_addr;
  assign unused_addr = ^in_addr;
  assign wr_word = in_data;
`endif

  assign level   = wptr - rptr;
  assign in_full = (level == LVL_W'(DEPTH));
  assign push    = in_wr && !in_full;

  // Zero-extension gives the {3'b000,addr[12:8]} first header byte.
  assign head_frame = SW'(mem[rptr[AW-1:0]]);

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= wr_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      ovf  <= 1'b0;
    end else begin
      if (push) wptr <= wptr + LVL_W'(1);
      if (in_wr && in_full) ovf <= 1'b1;
      else if (ovf_clr)     ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rptr      <= '0;
      sr        <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (level != '0) begin
            sr        <= head_frame << 8;
            out_data  <= head_frame[SW-1-:8];
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            cnt       <= '0;
            rptr      <= rptr + LVL_W'(1);
            state     <= SEND;
          end
        end
        SEND: begin
          if (out_valid && out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= IDLE;
            end else begin
              out_data <= sr[SW-1-:8];
              sr       <= sr << 8;
              cnt      <= cnt + 5'd1;
              out_last <= (cnt == 5'(NB - 2));
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puf_word_streamer.sv
// Scoreboard bench for puf_word_streamer: directed scenarios plus random
// traffic, expected bytes derived from the word framing rules.
module tb_puf_word_streamer;
  localparam int DEPTH = 4;
  localparam int LVL_W = 3;
`ifdef PUF_ADDR_HDR_EN
  localparam int NB = 18;
`else
  localparam int NB = 16;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_wr = 1'b0;
  logic [12:0]      in_addr = '0;
  logic [127:0]     in_data = '0;
  logic             in_full;
  logic             ovf;
  logic             ovf_clr = 1'b0;
  logic [LVL_W-1:0] level;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             out_last;

  int errors = 0;
  int checks = 0;
  int pending = 0;
  int xfers = 0;
  logic [8:0] sb [$];

  always #5 clk = ~clk;

  puf_word_streamer #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_wr(in_wr), .in_addr(in_addr),
    .in_data(in_data), .in_full(in_full), .ovf(ovf), .ovf_clr(ovf_clr),
    .level(level), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  task automatic chk(input string name, input logic [159:0] act,
                     input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected frame for one accepted word, straight from the byte-order rule.
  task automatic expect_word(input logic [12:0] a, input logic [127:0] d);
    logic [7:0] b;
    for (int i = 0; i < NB; i++) begin
`ifdef PUF_ADDR_HDR_EN
      if (i == 0)      b = {3'b000, a[12:8]};
      else if (i == 1) b = a[7:0];
      else             b = 8'(d >> (8 * (17 - i)));
`else
      b = 8'(d >> (8 * (15 - i)));
      if (a == 13'h1ABC) b = b;
`endif
      sb.push_back({(i == NB - 1), b});
    end
    pending++;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout", 160'(n < budget), 160'(1));
  endtask

  logic       pv, pr, pl, have_prev;
  logic [7:0] pd;
  logic [8:0] e;

  always @(negedge clk) begin
    if (!rst_n) begin
      have_prev = 1'b0;
    end else begin
      if (have_prev && pv && !pr) begin
        chk("stall_valid", 160'(out_valid), 160'(1));
        chk("stall_data", 160'({out_last, out_data}), 160'({pl, pd}));
      end
      if (out_valid && out_ready) begin
        xfers++;
        if (sb.size() == 0) begin
          chk("unexpected_byte", 160'({out_last, out_data}), 160'h1_ffff);
        end else begin
          e = sb.pop_front();
          chk("byte", 160'({out_last, out_data}), 160'(e));
          if (e[8]) pending--;
        end
      end
      pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
      have_prev = 1'b1;
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_full"}, 160'(in_full), 160'(0));
    chk({tag, "_ovf"}, 160'(ovf), 160'(0));
    chk({tag, "_level"}, 160'(level), 160'(0));
    chk({tag, "_data"}, 160'(out_data), 160'(0));
    chk({tag, "_valid"}, 160'(out_valid), 160'(0));
    chk({tag, "_last"}, 160'(out_last), 160'(0));
  endtask

  task automatic write1(input logic [12:0] a, input logic [127:0] d,
                        input bit exp_ok);
    in_wr = 1'b1; in_addr = a; in_data = d;
    if (exp_ok) expect_word(a, d);
    tick();
    in_wr = 1'b0;
  endtask

  int base, n;
  logic [127:0] rd;

  initial begin
    #12;
    chk_reset_vals("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Single word at full rate: latency and 16 back-to-back bytes.
    out_ready = 1'b1;
    write1(13'h1FFF, 128'h00112233_44556677_8899AABB_CCDDEEFF, 1);
    chk("lat_level", 160'(level), 160'(1));
    chk("lat_valid0", 160'(out_valid), 160'(0));
    tick();
    for (int i = 0; i < NB; i++) begin
      chk("burst_valid", 160'(out_valid), 160'(1));
      tick();
    end
    chk("frame_end_valid", 160'(out_valid), 160'(0));
    chk("frame_end_level", 160'(level), 160'(0));
    chk("frame_sb_empty", 160'(sb.size()), 160'(0));

    // Backpressure with a 1,0,0 ready pattern.
    base = xfers;
    write1(13'h0123, {$urandom, $urandom, $urandom, $urandom}, 1);
    for (int i = 0; i < 3 * NB + 6; i++) begin
      out_ready = (i % 3 == 0);
      tick();
    end
    drain(200);
    chk("bp_xfers", 160'(xfers - base), 160'(NB));

    // Overflow: one word stalled in the serializer, then 5 writes.
    out_ready = 1'b0;
    write1(13'h0001, 128'hA0, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      write1(13'(i + 2), 128'(i + 'hB0), i < 4);
      if (i == 3) begin
        chk("ovf_full", 160'(in_full), 160'(1));
        chk("ovf_not_yet", 160'(ovf), 160'(0));
      end
    end
    chk("ovf_set", 160'(ovf), 160'(1));
    chk("ovf_level", 160'(level), 160'(DEPTH));
    ovf_clr = 1'b1;
    write1(13'h0009, 128'hC0, 0);
    ovf_clr = 1'b0;
    chk("ovf_race", 160'(ovf), 160'(1));
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", 160'(ovf), 160'(0));
    drain(400);

    // Reset mid-frame after 5 bytes with 2 words queued.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      write1(13'(i), {$urandom, $urandom, $urandom, $urandom}, 1);
    tick();
    base = xfers;
    out_ready = 1'b1;
    n = 0;
    while (xfers < base + 5 && n < 100) begin
      tick();
      n++;
    end
    chk("rst_wait", 160'(n < 100), 160'(1));
    rst_n = 1'b0;
    out_ready = 1'b0;
    sb.delete();
    pending = 0;
    #1;
    chk_reset_vals("midrst");
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 25; i++) tick();
    chk("no_residual_level", 160'(level), 160'(0));
    chk("no_residual_valid", 160'(out_valid), 160'(0));
    base = xfers;
    write1(13'h0ABC, {$urandom, $urandom, $urandom, $urandom}, 1);
    drain(200);
    chk("post_rst_xfers", 160'(xfers - base), 160'(NB));

    // Random traffic, writes only when the FIFO cannot be full.
    for (int i = 0; i < 600; i++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      if (pending < DEPTH && $urandom_range(0, 9) < 2) begin
        rd = {$urandom, $urandom, $urandom, $urandom};
        in_wr = 1'b1;
        in_addr = 13'($urandom);
        in_data = rd;
        expect_word(in_addr, rd);
      end
      tick();
      in_wr = 1'b0;
    end
    drain(2000);
    chk("rand_no_ovf", 160'(ovf), 160'(0));
    chk("final_level", 160'(level), 160'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
